imm_enc: RTL and testbench
==========================

// Module: imm_enc
// PURPOSE
// - Inverse of the immediate extender. Takes a 32-bit constant or branch byte offset.
//   Emits the 16-bit imm + EOp beat(s) that the extender turns back into that value.
// - Sits in the constant-materialisation / test-generation path ahead of the datapath.
// - Single-beat encode when one EOp fits; otherwise a two-beat lui/ori split.
// PARAMETERS
// - none (widths fixed: value 32, imm 16, EOp 2)
// PORTS
// clk        in   1   clock, all state on rising edge
// reset      in   1   asynchronous, active-low reset
// in_valid   in   1   value/is_branch valid
// in_ready   out  1   encoder can accept a request
// value      in   32  constant (is_branch=0) or branch byte offset (is_branch=1)
// is_branch  in   1   1: encode with EOp=11 only
// out_valid  out  1   imm/EOp/last/err valid
// out_ready  in   1   consumer accepts current beat
// imm        out  16  immediate field
// EOp        out  2   00 sign-ext, 01 zero-ext, 10 hi-16, 11 sign-ext<<2
// last       out  1   final beat of this request
// err        out  1   value not encodable (branch only)
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE, out_valid=0, imm=0, EOp=00, last=0, err=0.
//   Any in-flight request is discarded. in_ready=1 from the first edge after release.
// - FSM IDLE -> EVAL -> EMIT1 -> [EMIT2] -> IDLE.
// - in_ready = (state==IDLE). Accept on in_valid&in_ready; value/is_branch are latched.
// - EVAL: exactly one cycle, selects encoding. First beat is valid 2 cycles after the accept edge.
// - Selection, non-branch, first match wins:
//   - value[31:15] all equal -> 1 beat: imm=value[15:0], EOp=00.
//   - value[31:16]==0 -> 1 beat: imm=value[15:0], EOp=01.
//   - value[15:0]==0 -> 1 beat: imm=value[31:16], EOp=10.
//   - else 2 beats: EMIT1 imm=value[31:16], EOp=10, last=0; EMIT2 imm=value[15:0], EOp=01, last=1.
// - Selection, branch: if value[1:0]==0 and value[31:17] all equal -> 1 beat imm=value[17:2], EOp=11, err=0.
//   Otherwise 1 beat imm=0, EOp=11, err=1.
// - Beat transfer on out_valid&out_ready. While out_valid&!out_ready, imm/EOp/last/err are held stable.
// - After the last beat transfers: out_valid=0 and state=IDLE.
//   No back-to-back accept in the same cycle (minimum 3 cycles per request).
// - Single-beat responses always have last=1. err=1 only when is_branch=1.
// - Round-trip invariant: single beat ext(imm,EOp)==value. Two-beat ext(hi,10)|ext(lo,01)==value.
// CONFIGURATION
// - IMM_ENC_CNT_EN defined: extra port cnt_split out 16.
//   - Counts requests resolved as two-beat splits; increments at the EVAL cycle.
//   - Saturates at 16'hFFFF; async reset to 0.
// - IMM_ENC_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
// - value=32'hFFFF_8000, br=0, out_ready=1 -> accept at T, beat at T+2: imm=8000, EOp=00, last=1.
// - value=32'h0000_ABCD -> imm=ABCD, EOp=01. value=32'h1234_0000 -> imm=1234, EOp=10. One beat each.
// - value=32'h1234_5678 with out_ready=0 for 3 cycles -> beat1 imm=1234/EOp=10/last=0 held stable;
//   then beat2 imm=5678/EOp=01/last=1. cnt_split +1 if IMM_ENC_CNT_EN.
// - br=1, value=32'hFFFF_FFFC -> imm=FFFF, EOp=11, err=0.
//   br=1, value=32'h0000_0002 -> imm=0, EOp=11, err=1.
// - reset=0 while beat1 of a split is pending -> out_valid=0 at once, no beat2.
//   in_ready=1 after release; next request is encoded normally.
// - Random 10k values, both br settings -> round-trip invariant holds for every err=0 response.

Source files
------------

// File: rtl/imm_enc.sv
// imm_enc: inverse of the immediate extender. Takes a 32-bit constant or branch byte
// offset and emits the 16-bit imm + EOp beat(s) that the extender maps back to it.
// Constants that fit one EOp are sent as one beat. Anything else is split into two
// beats: hi-16 (EOp=10) followed by zero-ext lo-16 (EOp=01), which together act as lui/ori.
//
// Ports:
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous active-low reset
//   in_valid   in   1   request valid (value/is_branch)
//   in_ready   out  1   encoder idle, can accept a request
//   value      in   32  constant or branch byte offset
//   is_branch  in   1   encode as branch offset (EOp=11 only)
//   out_valid  out  1   imm/EOp/last/err valid
//   out_ready  in   1   consumer accepts current beat
//   imm        out  16  immediate field
//   EOp        out  2   00 sign-ext, 01 zero-ext, 10 hi-16, 11 sign-ext<<2
//   last       out  1   final beat of the request
//   err        out  1   branch offset not encodable
//   cnt_split  out  16  (IMM_ENC_CNT_EN only) saturating count of two-beat splits
//
// Optional feature macro: IMM_ENC_CNT_EN adds the cnt_split port and its counter.
module imm_enc (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] value,
  input  logic        is_branch,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] imm,
  output logic [1:0]  EOp,
  output logic        last,
  output logic        err
`ifdef IMM_ENC_CNT_EN
  ,
  output logic [15:0] cnt_split
`endif
);

  typedef enum logic [1:0] {StIdle, StEval, StEmit1, StEmit2} state_e;

  state_e      state_q;
  logic [31:0] value_q;
  logic        br_q;

  // Encoding of the latched request, consumed in the EVAL cycle.
  logic [15:0] enc_imm;
  logic [1:0]  enc_eop;
  logic        enc_err;
  logic        enc_split;

  assign in_ready = (state_q == StIdle);

  always_comb begin
    enc_imm   = 16'h0000;
    enc_eop   = 2'b00;
    enc_err   = 1'b0;
    enc_split = 1'b0;
    if (br_q) begin
      enc_eop = 2'b11;
      // Word-aligned and within the 18-bit signed range reachable by imm<<2.
      if (value_q[1:0] == 2'b00 && value_q[31:17] == {15{value_q[17]}}) begin
        enc_imm = value_q[17:2];
      end else begin
        enc_err = 1'b1;
      end
    end else if (value_q[31:15] == {17{value_q[15]}}) begin
      enc_imm = value_q[15:0];
      enc_eop = 2'b00;
    end else if (value_q[31:16] == 16'h0000) begin
      enc_imm = value_q[15:0];
      enc_eop = 2'b01;
    end else if (value_q[15:0] == 16'h0000) begin
      enc_imm = value_q[31:16];
      enc_eop = 2'b10;
    end else begin
      // First beat of the split; the low half follows from value_q in EMIT2.
      enc_imm   = value_q[31:16];
      enc_eop   = 2'b10;
      enc_split = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      value_q   <= 32'h0;
      br_q      <= 1'b0;
      out_valid <= 1'b0;
      imm       <= 16'h0000;
      EOp       <= 2'b00;
      last      <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            value_q <= value;
            br_q    <= is_branch;
            state_q <= StEval;
          end
        end
        StEval: begin
          out_valid <= 1'b1;
          imm       <= enc_imm;
          EOp       <= enc_eop;
          last      <= !enc_split;
          err       <= enc_err;
          state_q   <= StEmit1;
        end
        StEmit1: begin
          if (out_ready) begin
            if (last) begin
              out_valid <= 1'b0;
              state_q   <= StIdle;
            end else begin
              imm     <= value_q[15:0];
              EOp     <= 2'b01;
              last    <= 1'b1;
              state_q <= StEmit2;
            end
          end
        end
        StEmit2: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef IMM_ENC_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_split <= 16'h0000;
    end else if (state_q == StEval && enc_split && cnt_split != 16'hFFFF) begin
      cnt_split <= cnt_split + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_imm_enc.sv
module tb_imm_enc;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] value = 32'h0;
  logic        is_branch = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] imm;
  logic [1:0]  EOp;
  logic        last;
  logic        err;
`ifdef IMM_ENC_CNT_EN
  logic [15:0] cnt_split;
`endif

  imm_enc dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .value     (value),
    .is_branch (is_branch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm       (imm),
    .EOp       (EOp),
    .last      (last),
    .err       (err)
`ifdef IMM_ENC_CNT_EN
    ,
    .cnt_split (cnt_split)
`endif
  );

  always #5 clk = ~clk;

  // rt=0: exact beat expected. rt=1: check round-trip of value v under branch mode br.
  typedef struct {
    logic        rt;
    logic [31:0] v;
    logic        br;
    logic [15:0] imm;
    logic [1:0]  eop;
    logic        last;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ext(input logic [15:0] i, input logic [1:0] op);
    case (op)
      2'b00:   ext = {{16{i[15]}}, i};
      2'b01:   ext = {16'h0000, i};
      2'b10:   ext = {i, 16'h0000};
      default: ext = {{14{i[15]}}, i, 2'b00};
    endcase
  endfunction

  function automatic exp_t beat(input logic [15:0] i, input logic [1:0] op, input logic l,
                                input logic e);
    exp_t x;
    x.rt = 1'b0; x.v = 32'h0; x.br = 1'b0;
    x.imm = i; x.eop = op; x.last = l; x.err = e;
    return x;
  endfunction

  function automatic exp_t rt_item(input logic [31:0] v, input logic br);
    exp_t x;
    x.rt = 1'b1; x.v = v; x.br = br;
    x.imm = 16'h0; x.eop = 2'b00; x.last = 1'b0; x.err = 1'b0;
    return x;
  endfunction

  // Monitor: pops the scoreboard whenever a beat transfers.
  logic [31:0] hi_acc = 32'h0;
  logic        have_hi = 1'b0;
  int          n_split = 0;
  logic        stall_seen = 1'b0;
  logic [19:0] snap = 20'h0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      hi_acc = 32'h0; have_hi = 1'b0; n_split = 0; stall_seen = 1'b0;
    end else begin
      if (out_valid && !out_ready) begin
        if (stall_seen) chk("hold_stable", {imm, EOp, last, err}, snap);
        snap = {imm, EOp, last, err};
        stall_seen = 1'b1;
      end else begin
        stall_seen = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (EOp == 2'b10 && !last) n_split++;
        if (sb.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = sb[0];
          if (!e.rt) begin
            chk("beat", {imm, EOp, last, err}, {e.imm, e.eop, e.last, e.err});
            void'(sb.pop_front());
          end else if (e.br) begin
            chk("rt_br_eop", EOp, 2'b11);
            chk("rt_br_last", last, 1'b1);
            if (err) begin
              chk("rt_br_err_imm", imm, 16'h0);
              chk("rt_br_err_justified", ext(e.v[17:2], 2'b11) == e.v, 1'b0);
            end else begin
              chk("rt_br_value", ext(imm, EOp), e.v);
            end
            void'(sb.pop_front());
          end else begin
            chk("rt_err", err, 1'b0);
            if (!last) begin
              chk("rt_hi_eop", EOp, 2'b10);
              chk("rt_hi_twice", have_hi, 1'b0);
              hi_acc = ext(imm, EOp);
              have_hi = 1'b1;
            end else begin
              if (have_hi) begin
                chk("rt_lo_eop", EOp, 2'b01);
                chk("rt_split_value", hi_acc | ext(imm, EOp), e.v);
              end else begin
                chk("rt_single_value", ext(imm, EOp), e.v);
              end
              have_hi = 1'b0;
              void'(sb.pop_front());
            end
          end
        end
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 just after the accept edge.
  task automatic send(input logic [31:0] v, input logic br);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 1, 0);
    end else begin
      in_valid = 1'b1; value = v; is_branch = br;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic dir1(input logic [31:0] v, input logic br, input logic [15:0] i,
                      input logic [1:0] op, input logic e);
    sb.push_back(beat(i, op, 1'b1, e));
    send(v, br);
    drain();
  endtask

  initial begin
    logic [31:0] r;
    int          k;
    logic        br;

    // Reset state.
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_fields", {imm, EOp, last, err}, 20'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1'b1);
`ifdef IMM_ENC_CNT_EN
    chk("rst_cnt", cnt_split, 16'h0);
`endif

    // Sign-extend with latency check: EVAL cycle then beat.
    sb.push_back(beat(16'h8000, 2'b00, 1'b1, 1'b0));
    send(32'hFFFF_8000, 1'b0);
    @(negedge clk);
    chk("lat_eval_idle", out_valid, 1'b0);
    @(negedge clk);
    chk("lat_beat_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    drain();

    dir1(32'h0000_ABCD, 1'b0, 16'hABCD, 2'b01, 1'b0);
    dir1(32'h1234_0000, 1'b0, 16'h1234, 2'b10, 1'b0);
    dir1(32'h0000_7FFF, 1'b0, 16'h7FFF, 2'b00, 1'b0);
    dir1(32'h0000_8000, 1'b0, 16'h8000, 2'b01, 1'b0);
    dir1(32'h0000_0000, 1'b0, 16'h0000, 2'b00, 1'b0);
    dir1(32'hFFFF_FFFC, 1'b1, 16'hFFFF, 2'b11, 1'b0);
    dir1(32'h0000_0002, 1'b1, 16'h0000, 2'b11, 1'b1);
    dir1(32'h0001_FFFC, 1'b1, 16'h7FFF, 2'b11, 1'b0);
    dir1(32'hFFFE_0000, 1'b1, 16'h8000, 2'b11, 1'b0);
    dir1(32'h0002_0000, 1'b1, 16'h0000, 2'b11, 1'b1);

    // Split with back-pressure on the first beat.
    out_ready = 1'b0;
    sb.push_back(beat(16'h1234, 2'b10, 1'b0, 1'b0));
    sb.push_back(beat(16'h5678, 2'b01, 1'b1, 1'b0));
    send(32'h1234_5678, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    chk("stall_valid", out_valid, 1'b1);
    chk("stall_last", last, 1'b0);
`ifdef IMM_ENC_CNT_EN
    chk("cnt_after_split", cnt_split, 16'h1);
`endif
    out_ready = 1'b1;
    drain();

    // Reset while beat1 of a split is pending.
    out_ready = 1'b0;
    sb.push_back(beat(16'hDEAD, 2'b10, 1'b0, 1'b0));
    sb.push_back(beat(16'hBEEF, 2'b01, 1'b1, 1'b0));
    send(32'hDEAD_BEEF, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_fields", {imm, EOp, last, err}, 20'h0);
`ifdef IMM_ENC_CNT_EN
    chk("midrst_cnt", cnt_split, 16'h0);
`endif
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("postrst_in_ready", in_ready, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    chk("postrst_no_beat2", out_valid, 1'b0);
    dir1(32'h0000_ABCD, 1'b0, 16'hABCD, 2'b01, 1'b0);

    // Random round-trip, biased toward each encoding class.
    for (int i = 0; i < 10000; i++) begin
      r  = $urandom;
      k  = $urandom_range(0, 3);
      br = ((i % 2) == 1);
      case (k)
        1: r = br ? {{14{r[17]}}, r[17:2], 2'b00} : {{16{r[15]}}, r[15:0]};
        2: r[31:16] = 16'h0;
        3: r[15:0] = 16'h0;
        default: ;
      endcase
      sb.push_back(rt_item(r, br));
      send(r, br);
    end
    drain();
`ifdef IMM_ENC_CNT_EN
    chk("cnt_final", cnt_split, n_split[15:0]);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
